// File: rtl/a2d_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : a2d_pkg                                                      |
// | Description : Shared types and constants for the A2D request arbiter:      |
// |               arbiter state enum, requester count, A2D channel map,        |
// |               invalid-channel test and round-robin pointer advance.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package a2d_pkg;

  localparam int NUM_REQ = 3;
  localparam int CH_W    = 3;
  localparam int RES_W   = 12;
  localparam int PTR_W   = 2;

  // A2D channel map; codes 5 and 6 have no converter input behind them.
  localparam logic [CH_W-1:0] CH_B1  = 3'd0;
  localparam logic [CH_W-1:0] CH_LP  = 3'd1;
  localparam logic [CH_W-1:0] CH_B3  = 3'd2;
  localparam logic [CH_W-1:0] CH_HP  = 3'd3;
  localparam logic [CH_W-1:0] CH_B2  = 3'd4;
  localparam logic [CH_W-1:0] CH_VOL = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } a2d_state_e;

  // Any code outside the channel map (i.e. 5 or 6) is invalid.
  function automatic logic ch_invalid(input logic [CH_W-1:0] ch);
    return !(ch inside {CH_B1, CH_LP, CH_B3, CH_HP, CH_B2, CH_VOL});
  endfunction

  // Pointer moves to the slot just after the requester that was served.
  function automatic logic [PTR_W-1:0] rr_next_ptr(input logic [NUM_REQ-1:0] g);
    case (g)
      3'b001:  return 2'd1;
      3'b010:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/a2d_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : a2d_rr_pick                                                  |
// | Description : Combinational round-robin selector. Picks the first set      |
// |               request at or after the pointer, searching upward modulo     |
// |               NUM_REQ.                                                     |
// | Ports       : req_i   - request vector                                     |
// |               ptr_i   - round-robin pointer (index of highest priority)    |
// |               win_o   - one-hot winner                                     |
// |               valid_o - at least one request present                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module a2d_rr_pick
  import a2d_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic               valid_o
);

  localparam logic [NUM_REQ-1:0] C_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [NUM_REQ-1:0] w_rot;
  logic [NUM_REQ-1:0] w_rot_win;

  // Rotate so the pointer slot lands at bit 0, take the lowest set bit,
  // then rotate the one-hot result back into requester order.
  assign w_rot     = NUM_REQ'({req_i, req_i} >> ptr_i);
  assign w_rot_win = w_rot & (~w_rot + C_ONE);
  assign win_o     = NUM_REQ'(({w_rot_win, w_rot_win} << ptr_i) >> NUM_REQ);
  assign valid_o   = |req_i;

endmodule
`default_nettype wire

// File: rtl/a2d_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : a2d_arb                                                      |
// | Description : Round-robin arbiter sharing one A2D converter between three  |
// |               requesters. Grants one requester, launches a conversion on   |
// |               its channel, returns the result and a done pulse.            |
// | Config      : define A2D_TIMEOUT_EN to enable the conversion watchdog      |
// |               (limit = TIMEOUT_CYCLES clk cycles in WAIT).                 |
// | Ports       : clk, rst        - clock / async active-high reset            |
// |               req, req_chnnl  - level requests, per-requester channel      |
// |               gnt, done       - one-hot grant, one-cycle completion pulse  |
// |               res, err, busy  - last result, its error flag, activity      |
// |               strt_cnv, chnnl - conversion start / channel to the A2D      |
// |               cnv_cmplt, a2d_res - completion strobe / result from the A2D |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module a2d_arb
  import a2d_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*CH_W-1:0] req_chnnl,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic [RES_W-1:0]        res,
  output logic                    err,
  output logic                    busy,
  output logic                    strt_cnv,
  output logic [CH_W-1:0]         chnnl,
  input  logic                    cnv_cmplt,
  input  logic [RES_W-1:0]        a2d_res
);

  // The watchdog counter cannot represent a limit below 2.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range_chk
    $error("a2d_arb: TIMEOUT_CYCLES must be at least 2");
  end

  a2d_state_e         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q,   ptr_d;
  logic [NUM_REQ-1:0] gnt_q,   gnt_d;
  logic [CH_W-1:0]    chnnl_q, chnnl_d;
  logic [RES_W-1:0]   res_q,   res_d;
  logic               err_q,   err_d;

`ifdef A2D_TIMEOUT_EN
  localparam int             WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  logic [NUM_REQ-1:0] w_pick_win;
  logic               w_pick_valid;
  logic [CH_W-1:0]    w_pick_ch;

  a2d_rr_pick u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .win_o   (w_pick_win),
    .valid_o (w_pick_valid)
  );

  // Channel of the winning requester, latched at grant time.
  always_comb begin
    w_pick_ch = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick_win[i]) begin
        w_pick_ch = req_chnnl[CH_W*i +: CH_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    chnnl_d = chnnl_q;
    res_d   = res_q;
    err_d   = err_q;
`ifdef A2D_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (w_pick_valid) begin
          gnt_d   = w_pick_win;
          chnnl_d = w_pick_ch;
          state_d = START;
        end
      end
      START: begin
        // Unmapped channels are rejected without touching the converter.
        if (ch_invalid(chnnl_q)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = WAIT;
`ifdef A2D_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      WAIT: begin
        if (cnv_cmplt) begin
          res_d   = a2d_res;
          err_d   = 1'b0;
          state_d = DONE;
`ifdef A2D_TIMEOUT_EN
        end else if (wd_q == WD_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wd_d    = wd_q + WD_W'(1);
`endif
        end
      end
      DONE: begin
        ptr_d   = rr_next_ptr(gnt_q);
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      chnnl_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
`ifdef A2D_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      chnnl_q <= chnnl_d;
      res_q   <= res_d;
      err_q   <= err_d;
`ifdef A2D_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  // Pulses are decoded from the registered state, so each lasts exactly
  // the one cycle spent in START or DONE.
  assign gnt      = gnt_q;
  assign done     = (state_q == DONE) ? gnt_q : '0;
  assign strt_cnv = (state_q == START) && !ch_invalid(chnnl_q);
  assign busy     = (state_q != IDLE);
  assign chnnl    = chnnl_q;
  assign res      = res_q;
  assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_a2d_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_a2d_arb                                                   |
// | Description : Self-checking bench for a2d_arb: transaction-level reference |
// |               model compared every cycle, plus directed scenarios with     |
// |               literal expectations.                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_a2d_arb;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [8:0]  req_chnnl = '0;
  logic [2:0]  gnt, done;
  logic [11:0] res;
  logic        err, busy, strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] a2d_res = '0;

  a2d_arb #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_chnnl (req_chnnl),
    .gnt       (gnt),
    .done      (done),
    .res       (res),
    .err       (err),
    .busy      (busy),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .cnv_cmplt (cnv_cmplt),
    .a2d_res   (a2d_res)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_strt   = 0;
  int n_done   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: bound expired, got no event, expected event", name);
  endtask

  // ---------------- reference model (transaction view) ----------------
  bit         m_active   = 0;  // a requester is being served
  bit         m_starting = 0;  // first cycle after grant
  bit         m_done     = 0;  // completion cycle
  int         m_who      = 0;
  int         m_ptr      = 0;
  int         m_waited   = 0;
  logic [2:0] m_ch       = '0;
  logic [11:0] m_res     = '0;
  bit         m_err      = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_starting = 0; m_done = 0; m_who = 0; m_ptr = 0;
      m_waited = 0; m_ch = '0; m_res = '0; m_err = 0;
    end else if (m_done) begin
      m_ptr    = (m_who + 1) % 3;
      m_active = 0;
      m_done   = 0;
    end else if (!m_active) begin
      bit found;
      found = 0;
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (m_ptr + k) % 3;
        if (!found && (((req >> idx) & 3'b001) != 3'b000)) begin
          found = 1;
          m_who = idx;
        end
      end
      if (found) begin
        m_active   = 1;
        m_starting = 1;
        m_ch       = 3'(req_chnnl >> (3 * m_who));
      end
    end else if (m_starting) begin
      m_starting = 0;
      if (m_ch == 3'd5 || m_ch == 3'd6) begin
        m_res = '0; m_err = 1; m_done = 1;
      end else begin
        m_waited = 0;
      end
    end else begin
      if (cnv_cmplt) begin
        m_res = a2d_res; m_err = 0; m_done = 1;
      end else begin
        m_waited++;
`ifdef A2D_TIMEOUT_EN
        if (m_waited == TO) begin
          m_res = '0; m_err = 1; m_done = 1;
        end
`endif
      end
    end
  end

  // Compare process: every cycle, on the falling edge.
  always @(negedge clk) begin
    check("gnt",      {29'd0, gnt},  m_active ? (32'd1 << m_who) : 32'd0);
    check("done",     {29'd0, done}, m_done ? (32'd1 << m_who) : 32'd0);
    check("strt_cnv", {31'd0, strt_cnv},
          {31'd0, m_active && m_starting && !(m_ch == 3'd5 || m_ch == 3'd6)});
    check("busy",     {31'd0, busy},  {31'd0, m_active});
    check("chnnl",    {29'd0, chnnl}, {29'd0, m_ch});
    check("res",      {20'd0, res},   {20'd0, m_res});
    check("err",      {31'd0, err},   {31'd0, m_err});
    if (strt_cnv) n_strt++;
    if (done != 3'b000) n_done++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_strt(input string name, input int maxc);
    int i;
    i = 0;
    while (!strt_cnv && i < maxc) begin
      step(1);
      i++;
    end
    if (!strt_cnv) bound_fail(name);
  endtask

  task automatic wait_done(input string name, input int maxc, output int cyc);
    cyc = 0;
    while (done == 3'b000 && cyc < maxc) begin
      step(1);
      cyc++;
    end
    if (done == 3'b000) bound_fail(name);
  endtask

  // Completes a conversion already in WAIT after 'dly' cycles.
  task automatic complete(input int dly, input logic [11:0] val);
    step(dly);
    cnv_cmplt = 1'b1;
    a2d_res   = val;
    step(1);
    cnv_cmplt = 1'b0;
    a2d_res   = '0;
  endtask

  function automatic int oh2idx(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_gnt"},   {29'd0, gnt},      32'd0);
    check({tag, "_done"},  {29'd0, done},     32'd0);
    check({tag, "_strt"},  {31'd0, strt_cnv}, 32'd0);
    check({tag, "_chnnl"}, {29'd0, chnnl},    32'd0);
    check({tag, "_res"},   {20'd0, res},      32'd0);
    check({tag, "_err"},   {31'd0, err},      32'd0);
    check({tag, "_busy"},  {31'd0, busy},     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int cyc, s0, d0;
    int order[4];
    int exp_order[4];
    exp_order = '{0, 1, 2, 0};

    step(2);
    check_reset_vals("reset");
    rst = 1'b0;
    step(2);

    // cnv_cmplt while idle must be ignored
    cnv_cmplt = 1'b1; a2d_res = 12'hFFF;
    step(1);
    cnv_cmplt = 1'b0; a2d_res = '0;
    step(1);
    check("stray_cmplt_busy", {31'd0, busy}, 32'd0);
    check("stray_cmplt_res",  {20'd0, res},  32'd0);

    // Single request, channel 7, result ABC
    s0 = n_strt;
    req = 3'b001; req_chnnl = 9'b000_000_111;
    wait_strt("s1_strt", 5);
    check("s1_chnnl", {29'd0, chnnl}, 32'd7);
    complete(10, 12'hABC);
    wait_done("s1_done", 3, cyc);
    check("s1_done", {29'd0, done}, 32'b001);
    check("s1_res",  {20'd0, res},  32'hABC);
    check("s1_err",  {31'd0, err},  32'd0);
    req = 3'b000;
    step(2);
    check("s1_strt_count", n_strt - s0, 32'd1);

    // Requester 2 drops req mid-transaction; still gets done and result
    req = 3'b100; req_chnnl = 9'b011_000_000;
    wait_strt("s1b_strt", 5);
    req = 3'b000; req_chnnl = 9'b111_111_111;
    complete(3, 12'h123);
    wait_done("s1b_done", 3, cyc);
    check("s1b_done",  {29'd0, done},  32'b100);
    check("s1b_res",   {20'd0, res},   32'h123);
    check("s1b_chnnl", {29'd0, chnnl}, 32'd3);
    step(2);

    // Simultaneous requests held, pointer at 0
    req = 3'b111; req_chnnl = {3'd4, 3'd1, 3'd0};
    for (int t = 0; t < 4; t++) begin
      wait_strt("s2_strt", 5);
      complete(2, 12'h100 + 12'(t));
      wait_done("s2_done", 3, cyc);
      order[t] = oh2idx(done);
      check("s2_done_eq_gnt", {29'd0, done}, {29'd0, gnt});
      check("s2_order", order[t], exp_order[t]);
      if (t == 3) req = 3'b000;
      step(1);
    end
    step(1);

    // Invalid channel 5 on requester 1
    s0 = n_strt;
    req = 3'b010; req_chnnl = 9'b000_101_000;
    wait_done("s3_done", 4, cyc);
    check("s3_latency_le3", {31'd0, (cyc <= 3)}, 32'd1);
    check("s3_done", {29'd0, done}, 32'b010);
    check("s3_err",  {31'd0, err},  32'd1);
    check("s3_res",  {20'd0, res},  32'd0);
    req = 3'b000;
    step(2);
    check("s3_no_strt", n_strt - s0, 32'd0);

    // Conversion that never completes
    req = 3'b001; req_chnnl = 9'b000_000_000;
    wait_strt("s4_strt", 5);
`ifdef A2D_TIMEOUT_EN
    wait_done("s4_timeout_done", 30, cyc);
    check("s4_timeout_cycles", cyc, 32'd17);
    check("s4_done", {29'd0, done}, 32'b001);
    check("s4_err",  {31'd0, err},  32'd1);
    check("s4_res",  {20'd0, res},  32'd0);
`else
    d0 = n_done;
    step(1005);
    check("s4_hold_busy", {31'd0, busy}, 32'd1);
    check("s4_hold_nodone", n_done - d0, 32'd0);
    complete(0, 12'h555);
    wait_done("s4_done", 3, cyc);
    check("s4_res", {20'd0, res}, 32'h555);
    check("s4_err", {31'd0, err}, 32'd0);
`endif
    req = 3'b000;
    step(2);

    // Reset asserted while in WAIT
    req = 3'b100; req_chnnl = 9'b010_000_000;
    wait_strt("s5_strt", 5);
    step(2);
    d0 = n_done;
    rst = 1'b1;
    req = 3'b000;
    step(1);
    check_reset_vals("s5_rst_a");
    step(1);
    check_reset_vals("s5_rst_b");
    rst = 1'b0;
    step(2);
    check("s5_no_done", n_done - d0, 32'd0);

    // Pointer restarts at 0: 0 beats 2
    req = 3'b101; req_chnnl = 9'b001_000_010;
    wait_strt("s5_ptr_strt", 5);
    check("s5_ptr_reset_gnt", {29'd0, gnt}, 32'b001);
    complete(1, 12'h0F0);
    wait_done("s5_ptr_done", 3, cyc);
    req = 3'b000;
    step(2);

    // New request from requester 2 completes normally
    req = 3'b100; req_chnnl = 9'b010_000_000;
    wait_strt("s5_new_strt", 5);
    complete(4, 12'h3C3);
    wait_done("s5_new_done", 3, cyc);
    check("s5_new_done", {29'd0, done}, 32'b100);
    check("s5_new_res",  {20'd0, res},  32'h3C3);
    check("s5_new_err",  {31'd0, err},  32'd0);
    req = 3'b000;
    step(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
